// File: rtl/memory_port_arbiter_if.sv
// Bundle of fetch, data and memory-side signals around the shared memory port.
// slave = arbiter view, master = CPU stages plus memory.
interface memory_port_arbiter_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16
);
  logic                  i_req;
  logic [ADDR_WIDTH-1:0] i_addr;
  logic                  i_flush;
  logic                  i_ready;
  logic [DATA_WIDTH-1:0] i_data;
  logic                  d_req;
  logic                  d_write;
  logic [ADDR_WIDTH-1:0] d_addr;
  logic [DATA_WIDTH-1:0] d_wdata;
  logic                  d_ready;
  logic [DATA_WIDTH-1:0] d_rdata;
  logic                  i_wait;
  logic                  d_wait;
  logic                  mem_req;
  logic                  mem_write;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_ack;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport slave (
    input  i_req, i_addr, i_flush, d_req, d_write, d_addr, d_wdata, mem_ack, mem_rdata,
    output i_ready, i_data, d_ready, d_rdata, i_wait, d_wait,
           mem_req, mem_write, mem_addr, mem_wdata
  );

  modport master (
    output i_req, i_addr, i_flush, d_req, d_write, d_addr, d_wdata, mem_ack, mem_rdata,
    input  i_ready, i_data, d_ready, d_rdata, i_wait, d_wait,
           mem_req, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/memory_port_arbiter.sv
// Serializes instruction-fetch and data-memory accesses onto one memory port,
// data-first with a bounded burst so a pending fetch is never starved.
module memory_port_arbiter #(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 16,
  parameter int D_BURST_MAX = 4
) (
  input  logic clk,
  input  logic reset,
  memory_port_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY, RESP} state_t;

  localparam logic [2:0] BURST_MAX = 3'(D_BURST_MAX);

  state_t     state, state_nxt;
  logic       owner_d;    // 1 = data stage owns the port
  logic       drop;
  logic [2:0] burst_cnt;
  logic       i_rdy_q;
  logic       i_req_eff;
  logic       grant_d, grant_i;

  assign i_req_eff = bus.i_req & ~bus.i_flush;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    grant_d   = 1'b0;
    grant_i   = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.d_req && !(i_req_eff && burst_cnt == BURST_MAX)) begin
          grant_d   = 1'b1;
          state_nxt = D_BUSY;
        end else if (i_req_eff) begin
          grant_i   = 1'b1;
          state_nxt = I_BUSY;
        end
      end
      I_BUSY, D_BUSY: if (bus.mem_ack) state_nxt = RESP;
      RESP:           state_nxt = IDLE;
      default:        state_nxt = IDLE;
    endcase
  end

  // A flush landing in the ready cycle itself still kills the fetch pulse.
  always_comb begin
    bus.i_ready = i_rdy_q & ~bus.i_flush;
    bus.i_wait  = bus.i_req & ~bus.i_ready;
    bus.d_wait  = bus.d_req & ~bus.d_ready;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      owner_d       <= 1'b0;
      drop          <= 1'b0;
      burst_cnt     <= '0;
      i_rdy_q       <= 1'b0;
      bus.d_ready   <= 1'b0;
      bus.i_data    <= '0;
      bus.d_rdata   <= '0;
      bus.mem_req   <= 1'b0;
      bus.mem_write <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
    end else begin
      i_rdy_q     <= 1'b0;
      bus.d_ready <= 1'b0;
      unique case (state)
        IDLE: begin
          if (grant_d || grant_i) begin
            owner_d       <= grant_d;
            bus.mem_req   <= 1'b1;
            bus.mem_write <= grant_d & bus.d_write;
            bus.mem_addr  <= grant_d ? bus.d_addr  : bus.i_addr;
            bus.mem_wdata <= grant_d ? bus.d_wdata : '0;
            if (grant_i || !i_req_eff)     burst_cnt <= '0;
            else if (burst_cnt != BURST_MAX) burst_cnt <= burst_cnt + 3'd1;
          end
        end
        I_BUSY, D_BUSY: begin
          // The access cannot be aborted; a flush only suppresses the pulse.
          if (state == I_BUSY && bus.i_flush) drop <= 1'b1;
          if (bus.mem_ack) begin
            bus.mem_req <= 1'b0;
            if (!owner_d) begin
              bus.i_data <= bus.mem_rdata;
              i_rdy_q    <= ~drop & ~bus.i_flush;
            end else begin
              bus.d_ready <= 1'b1;
              if (!bus.mem_write) bus.d_rdata <= bus.mem_rdata;
            end
          end
        end
        RESP:    drop <= 1'b0;
        default: ;
      endcase
    end
  end
endmodule

// File: doc/memory_port_arbiter.md
# memory_port_arbiter

Shares the single 16-bit memory port between the instruction-fetch stage and the data-memory stage of the pipelined TSC CPU. It serializes requests through a small FSM, keeps memory-side signals stable until the memory acknowledges, and returns one-cycle completion pulses. It produces `i_wait`/`d_wait`, which the hazard logic uses to drive the IF/ID `stall` and downstream stage stalls. It also honours a fetch flush from branch resolution.

## Interface
- `ADDR_WIDTH`, default 16: width of all address ports.
- `DATA_WIDTH`, default 16: width of all data ports.
- `D_BURST_MAX`, default 4: maximum consecutive data grants while a fetch is pending.
- `clk`  in  1  single clock; everything is updated on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `i_req`  in  1  fetch request; held high until `i_ready` or a flush.
- `i_addr`  in  ADDR_WIDTH  fetch address.
- `i_flush`  in  1  discards any pending or in-flight fetch.
- `i_ready`  out  1  one-cycle pulse; `i_data` is valid.
- `i_data`  out  DATA_WIDTH  fetched instruction, registered.
- `d_req`  in  1  data request; held high until `d_ready`.
- `d_write`  in  1  1 = store, 0 = load.
- `d_addr`  in  ADDR_WIDTH  data address.
- `d_wdata`  in  DATA_WIDTH  store data.
- `d_ready`  out  1  one-cycle pulse on load or store completion.
- `d_rdata`  out  DATA_WIDTH  load data, registered.
- `i_wait`  out  1  combinational: `i_req & ~i_ready`.
- `d_wait`  out  1  combinational: `d_req & ~d_ready`.
- `mem_req`  out  1  memory access request.
- `mem_write`  out  1  memory write enable.
- `mem_addr`  out  ADDR_WIDTH  memory address.
- `mem_wdata`  out  DATA_WIDTH  memory write data.
- `mem_ack`  in  1  memory completion; sampled only while `mem_req` is high.
- `mem_rdata`  in  DATA_WIDTH  memory read data, valid with `mem_ack`.

## Operation
- **States:** IDLE, I_BUSY, D_BUSY, RESP. A one-bit `owner` register records I or D. A `drop` flag marks a flushed fetch. A 3-bit `burst_cnt` counts consecutive data grants.
- **IDLE arbitration:**
  - Data wins, unless `i_req & ~i_flush` is high and `burst_cnt == D_BURST_MAX`; then the fetch wins.
  - On a grant, latch address, write flag and write data into the `mem_*` registers. Set `mem_req` = 1 and go to I_BUSY or D_BUSY.
  - `i_req` is ignored in any cycle where `i_flush` = 1.
- **burst_cnt:**
  - Increments, saturating at D_BURST_MAX, on a data grant while `i_req` is high.
  - Clears on any fetch grant, or on any grant where `i_req` is low.
- **I_BUSY / D_BUSY:**
  - `mem_req`, `mem_write`, `mem_addr` and `mem_wdata` stay constant.
  - On `mem_ack`: set `mem_req` = 0 and go to RESP. A load or fetch captures `mem_rdata` into `i_data` or `d_rdata`.
  - A store leaves `d_rdata` unchanged.
- **RESP (one cycle):**
  - Pulse `i_ready` or `d_ready` according to `owner`.
  - `i_ready` is suppressed if `drop` = 1 or `i_flush` = 1 in this cycle.
  - Clear `drop` and return to IDLE.
  - No new grant is issued from RESP, so a requester has one cycle to retire its request.
- **Flush during I_BUSY:** set `drop`. The memory access still completes because it cannot be aborted, and its data still lands in `i_data`, but no `i_ready` is issued. A flush during D_BUSY has no effect.
- `mem_ack` while in IDLE or RESP is ignored.
- **Reset:** state = IDLE; `owner`, `drop` and `burst_cnt` = 0. All registered outputs are 0: `i_ready`, `d_ready`, `i_data`, `d_rdata`, `mem_req`, `mem_write`, `mem_addr`, `mem_wdata`. Reset mid-transaction abandons the access with no ready pulse. `i_wait`/`d_wait` follow their requests, since both ready outputs are 0.

## Timing
- Request sampled in IDLE at edge 0 → `mem_req` high from cycle 1.
- `mem_ack` in cycle k (k ≥ 1) → ready pulse in cycle k+1 → IDLE in cycle k+2.
- Minimum turnaround is 3 cycles per access when memory acks in its first request cycle.
- Between consecutive grants, `mem_req` is low for at least 2 cycles: the RESP cycle and the following IDLE cycle.
- A simultaneous `i_req` and `d_req` in IDLE grants data; the fetch is served after the data access, at the earliest.
- A fetch waits at most D_BURST_MAX data accesses.

## Test plan
- **Single fetch:** `i_req`=1, `i_addr`=0x0010, memory acks 2 cycles after `mem_req` with 0x6A01 → `mem_addr`=0x0010, `mem_write`=0. `i_ready` pulses once, with `i_data`=0x6A01, 3 cycles after `mem_req` rises. `i_wait` is 1 until then.
- **Simultaneous requests:** `i_req` and a `d_req` load @0x0100 (mem returns 0x1234) in the same cycle → the data access is granted first and `d_ready` pulses with 0x1234. The fetch is then granted, with `mem_req` low for 2 cycles between the accesses.
- **Store:** `d_write`=1, `d_addr`=0x0200, `d_wdata`=0xBEEF → `mem_write`=1, `mem_wdata`=0xBEEF, held until ack. `d_ready` pulses and `d_rdata` is unchanged.
- **Starvation bound:** `d_req` held for 6 accesses with `i_req` high throughout → grant order D,D,D,D,I,D…; the fetch is served 5th.
- **Flush:** `i_flush` pulsed while in I_BUSY → the memory access completes and `i_data` updates, but no `i_ready` pulse occurs. The next `i_req` @0x0020 completes normally.
- **Reset mid-access:** `reset` asserted in D_BUSY → the next cycle has `mem_req`=0, all ready outputs 0, state IDLE. A stale `mem_ack` one cycle later produces no pulse.
